// File: rtl/write_decoder8_pkg.sv
// -----------------------------------------------------------------------------
// write_decoder8_pkg
// Shared constants and types for the write-side 8:1 destination decoder.
//   NUM_DEST / SEL_W : destination count and select width
//   wd_state_e       : controller state (IDLE, ISSUE, BCAST)
//   LAST_IDX         : last destination visited by a broadcast
//   ZERO_REG_EN      : 1 when destination 7 is a hardwired-zero register
// Build option: WRDEC_ZERO_REG_EN (destination 7 not writable).
// -----------------------------------------------------------------------------
package write_decoder8_pkg;

  localparam int NUM_DEST = 8;
  localparam int SEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BCAST = 2'd2
  } wd_state_e;

`ifdef WRDEC_ZERO_REG_EN
  localparam logic [SEL_W-1:0] LAST_IDX    = 3'd6;
  localparam logic             ZERO_REG_EN = 1'b1;
`else
  localparam logic [SEL_W-1:0] LAST_IDX    = 3'd7;
  localparam logic             ZERO_REG_EN = 1'b0;
`endif

endpackage

// File: rtl/write_decoder8_decoder3_8.sv
// -----------------------------------------------------------------------------
// decoder3_8
// Combinational 3-to-8 one-hot decoder with enable.
//   en     : when 0 the output is all zeros
//   idx    : index of the bit to set
//   onehot : 1 << idx when enabled, else 0
// -----------------------------------------------------------------------------
module decoder3_8
  import write_decoder8_pkg::*;
(
  input  logic                en,
  input  logic [SEL_W-1:0]    idx,
  output logic [NUM_DEST-1:0] onehot
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // onehot unassigned, which would infer a latch.
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/write_decoder8.sv
// -----------------------------------------------------------------------------
// write_decoder8
// Write-side destination decoder between write-back and the register bank.
// Accepts one request per valid/ready handshake: a single write drives a
// one-hot enable for one cycle; a broadcast walks the enable across all
// writable destinations on consecutive cycles with the same data.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   in_valid : request present        in_ready : request can be taken
//   in_sel   : destination index      in_bcast : write every destination
//   in_data  : write data
//   out_en   : one-hot write enable   out_data : data with out_en
//   busy     : broadcast in progress
// Build option: WRDEC_ZERO_REG_EN makes destination 7 a hardwired-zero
// register (never enabled, broadcast stops at 6).
// -----------------------------------------------------------------------------
module write_decoder8
  import write_decoder8_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_bcast,
  input  logic [WIDTH-1:0]    in_data,
  output logic [NUM_DEST-1:0] out_en,
  output logic [WIDTH-1:0]    out_data,
  output logic                busy
);

  wd_state_e           state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [NUM_DEST-1:0] out_en_q, out_en_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;

  logic                dec_req;
  logic                dec_en;
  logic [SEL_W-1:0]    dec_idx;
  logic                accept;

  // Handshake outputs come from registered state only.
  assign in_ready = (state_q != BCAST) || (cnt_q == LAST_IDX);
  assign busy     = (state_q == BCAST);
  assign accept   = in_valid && in_ready;

  // A hardwired-zero destination swallows its write: the request still
  // completes, the enable is just suppressed.
  assign dec_en = dec_req && !(ZERO_REG_EN && (dec_idx == 3'd7));

  decoder3_8 u_dec (
    .en     (dec_en),
    .idx    (dec_idx),
    .onehot (out_en_d)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    dec_req    = 1'b0;
    dec_idx    = '0;

    if (accept) begin
      // Also covers the last broadcast cycle, so a new request follows
      // with no gap.
      dec_req    = 1'b1;
      out_data_d = in_data;
      if (in_bcast) begin
        state_d = BCAST;
        cnt_d   = '0;
        dec_idx = '0;
      end else begin
        state_d = ISSUE;
        dec_idx = in_sel;
      end
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        ISSUE: state_d = IDLE;
        BCAST: begin
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            dec_req = 1'b1;
            dec_idx = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_en_q   <= '0;
      out_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_en   = out_en_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_write_decoder8.sv
// -----------------------------------------------------------------------------
// tb_write_decoder8
// Directed bench for write_decoder8: reset, single writes, back-to-back
// writes, broadcast with a held follow-on request, reset mid-broadcast.
// Honors WRDEC_ZERO_REG_EN for the expected values.
// -----------------------------------------------------------------------------
module tb_write_decoder8;

  localparam int WIDTH = 64;

`ifdef WRDEC_ZERO_REG_EN
  localparam int LAST = 6;
  localparam logic [7:0] EN7 = 8'h00;
`else
  localparam int LAST = 7;
  localparam logic [7:0] EN7 = 8'h80;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic             in_bcast;
  logic [WIDTH-1:0] in_data;
  logic [7:0]       out_en;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  write_decoder8 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .in_data  (in_data),
    .out_en   (out_en),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sel   = '0;
    in_bcast = 1'b0;
    in_data  = '0;

    // Reset state before any clock edge.
    #1;
    check("rst_en",    out_en,   0);
    check("rst_data",  out_data, 0);
    check("rst_busy",  busy,     0);
    check("rst_ready", in_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Make the outputs non-zero, then reset mid-cycle with no edge.
    in_valid = 1'b1; in_sel = 3'd2; in_data = 64'hAA;
    tick();
    in_valid = 1'b0;
    check("pre_rst_en",   out_en,   8'h04);
    check("pre_rst_data", out_data, 64'hAA);
    #2 reset = 1'b0;
    #1;
    check("async_rst_en",    out_en,   0);
    check("async_rst_data",  out_data, 0);
    check("async_rst_busy",  busy,     0);
    check("async_rst_ready", in_ready, 1);
    #1 reset = 1'b1;
    tick();

    // Single write to 5.
    in_valid = 1'b1; in_sel = 3'd5; in_data = 64'hDEAD_BEEF;
    check("single_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("single_en",   out_en,   8'b0010_0000);
    check("single_data", out_data, 64'hDEAD_BEEF);
    check("single_busy", busy,     0);
    tick();
    check("single_en_off",   out_en,   0);
    check("single_data_hld", out_data, 64'hDEAD_BEEF);

    // Back-to-back writes to 0, 3, 7.
    in_valid = 1'b1; in_sel = 3'd0; in_data = 64'h10;
    tick();
    check("b2b0_en",    out_en,   8'h01);
    check("b2b0_ready", in_ready, 1);
    in_sel = 3'd3; in_data = 64'h13;
    tick();
    check("b2b3_en",    out_en,   8'h08);
    check("b2b3_data",  out_data, 64'h13);
    check("b2b3_ready", in_ready, 1);
    in_sel = 3'd7; in_data = 64'h17;
    tick();
    in_valid = 1'b0;
    check("b2b7_en",    out_en,   EN7);
    check("b2b7_ready", in_ready, 1);
    check("b2b7_busy",  busy,     0);
    tick();
    check("b2b_idle_en", out_en, 0);

    // Broadcast with a single write held on the input meanwhile.
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd5; in_data = 64'h1234;
    tick();
    in_bcast = 1'b0; in_sel = 3'd2; in_data = 64'h5555;
    for (int k = 0; k <= LAST; k++) begin
      check($sformatf("bc_en_%0d", k),    out_en,   8'h01 << k);
      check($sformatf("bc_busy_%0d", k),  busy,     1);
      check($sformatf("bc_data_%0d", k),  out_data, 64'h1234);
      check($sformatf("bc_ready_%0d", k), in_ready, (k == LAST) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    check("bc_next_en",   out_en,   8'h04);
    check("bc_next_data", out_data, 64'h5555);
    check("bc_next_busy", busy,     0);
    tick();
    check("bc_after_en", out_en, 0);

    // Reset during the out_en=0x08 broadcast cycle.
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 64'h77;
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    check("mbr_en0", out_en, 8'h01);
    tick();
    tick();
    tick();
    check("mbr_en3", out_en, 8'h08);
    #2 reset = 1'b0;
    #1;
    check("mbr_rst_en",    out_en,   0);
    check("mbr_rst_busy",  busy,     0);
    check("mbr_rst_ready", in_ready, 1);
    check("mbr_rst_data",  out_data, 0);
    #1 reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("mbr_post_en_%0d", c),   out_en, 0);
      check($sformatf("mbr_post_busy_%0d", c), busy,   0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_decoder8.md
# write_decoder8

Write-side counterpart to the 8:1 read select: takes one write request (3-bit destination select + data) and drives a one-hot write enable to one of eight destinations, e.g. register-file rows. Also supports a broadcast request that writes the same data to all destinations over consecutive cycles. Sits between the CPU write-back stage and the register bank, with a valid/ready handshake on its input.

## Interface
- `WIDTH`, 64, data width in bits
- `clk`  input  1  sole clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  write request present
- `in_ready`  output  1  block can accept a request this cycle
- `in_sel`  input  3  destination index 0..7; ignored when `in_bcast`=1
- `in_bcast`  input  1  write `in_data` to every destination
- `in_data`  input  WIDTH  write data
- `out_en`  output  8  one-hot write enable, at most one bit high per cycle
- `out_data`  output  WIDTH  data accompanying `out_en`
- `busy`  output  1  broadcast sequence in progress

## Operation
- Request accepted on a rising edge where `in_valid && in_ready`.
- States:
  - IDLE: nothing pending.
  - ISSUE: one single write on outputs this cycle.
  - BCAST: 3-bit counter `cnt` walking destinations.
- Transitions:
  - Accept with `in_bcast`=0 -> ISSUE: `out_en` = 1<<`in_sel`, `out_data` = `in_data`.
  - Accept with `in_bcast`=1 -> BCAST: `cnt`=0, data latched.
  - ISSUE with no accept -> IDLE; ISSUE with accept -> per the new request.
  - BCAST: `out_en` = 1<<`cnt`, `cnt` increments each cycle.
  - BCAST at last index (`cnt`=7) -> IDLE, or straight to the new request if one is accepted that cycle.
- `in_ready` = 1 in IDLE and ISSUE, and in BCAST only when `cnt` is the last index. Otherwise 0.
- `busy` = 1 in BCAST, 0 otherwise.
- `out_en` = 0 in IDLE. `out_data` holds its last value when `out_en`=0 and has no meaning then.
- `cnt` wraps 7->0 with no side effects. It is not used outside BCAST.
- Simultaneous events:
  - `in_valid` while `in_ready`=0: the request is not taken. The source must hold it stable.
  - Accept during the last BCAST cycle: no gap cycle.
- Reset (asynchronous, any state, including mid-broadcast): state=IDLE, `cnt`=0, `out_en`=0, `out_data`=0, `busy`=0, `in_ready`=1 immediately. Remaining broadcast writes are dropped.

## Timing
- Single write: accepted at edge N -> `out_en` valid during cycle N+1 only. Latency 1 cycle, throughput 1 write per cycle.
- Broadcast: accepted at edge N -> `out_en[k]` during cycle N+1+k for k=0..7. The next request can be accepted at edge N+8 and issues in cycle N+9.
- All outputs are registered. `in_ready` and `busy` are decoded from registered state only; no combinational path from inputs to outputs.

## Configuration
- `WRDEC_ZERO_REG_EN` defined: destination 7 is a hardwired-zero register.
  - `out_en[7]` is never asserted.
  - Single write to 7 is accepted and consumed: 1-cycle ISSUE with `out_en`=0.
  - Broadcast covers 0..6 only (7 cycles). Its last index, and the cycle `in_ready` returns to 1, is `cnt`=6.
- Not defined: all eight destinations are writable, as described above.

## Structure
- Package `write_decoder8_pkg`:
  - `NUM_DEST`=8, `SEL_W`=3
  - state enum `wd_state_e` {IDLE, ISSUE, BCAST}
  - last-index constant selected by `WRDEC_ZERO_REG_EN`
- Sub-module `decoder3_8`: combinational enable + 3-bit index -> 8-bit one-hot, used for `out_en` generation.

## Test plan
- Reset: assert `reset`=0 mid-cycle with no clock edge -> `out_en`=0, `out_data`=0, `busy`=0, `in_ready`=1 at once.
- Single write: sel=5, data=0xDEAD_BEEF at edge N -> cycle N+1 `out_en`=8'b0010_0000, `out_data`=0xDEAD_BEEF; cycle N+2 `out_en`=0.
- Back-to-back: sel 0,3,7 on three consecutive edges -> `out_en` 0x01, 0x08, 0x80 on consecutive cycles, `in_ready` held 1.
- Broadcast: data=0x1234 at edge N -> `out_en` walks 0x01..0x80 over cycles N+1..N+8, `busy` high for that span. `in_ready`=0 for cycles N+1..N+7; a request held on `in_valid` meanwhile is accepted at N+8.
- Reset mid-broadcast: `reset` low during the `out_en`=0x08 cycle -> `out_en`=0 at once. After release: IDLE, no further enables.
- `WRDEC_ZERO_REG_EN` build:
  - single write to 7 -> no enable
  - broadcast -> 0x01..0x40 over 7 cycles, `in_ready` back to 1 on the 7th cycle.
